// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for mem_port_arbiter       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_t;

    // Width of the starvation counter; holds MAX_WAIT up to 15.
    localparam int WAIT_W = 4;

    // Pick the 32-bit instruction word out of a 64-bit memory doubleword.
    function automatic logic [31:0] sel_word(input logic [63:0] i_dword,
                                             input logic        i_hi);
        return i_hi ? i_dword[63:32] : i_dword[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter_if : IF/DM requester and memory-side bus bundle    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    // Data-memory requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    // Unified memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Pipeline hold controls
    logic              stall_if;
    logic              stall_mem;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_valid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output stall_if, stall_mem
    );

    // Requesters plus memory view
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_valid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  stall_if, stall_mem
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_pick : combinational IF/DM winner selection                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              i_if_req,
    input  logic              i_dm_req,
    input  logic [WAIT_W-1:0] i_starve_cnt,
    output src_t              o_winner,
    output logic              o_gnt_vld
);

    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic w_if_forced;

    // IF only beats a pending DM once DM has used up its run of wins.
    assign w_if_forced = (i_starve_cnt == C_MAX_WAIT);

    always_comb begin
        o_winner  = SRC_DM;
        o_gnt_vld = i_if_req | i_dm_req;
        if (i_if_req && (!i_dm_req || w_if_forced)) begin
            o_winner = SRC_IF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between IF and DM        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    state_t              r_state;
    state_t              w_state_nxt;
    src_t                w_winner;
    logic                w_gnt_vld;
    logic                w_arb_pt;
    logic                w_take;
    logic                w_take_if;
    logic                w_take_dm;
    logic                w_done_if;
    logic                w_done_dm;

    logic [WAIT_W-1:0]   r_starve_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_if_hi;
    logic                r_if_gnt;
    logic                r_dm_gnt;
    logic                r_if_valid;
    logic                r_dm_valid;
    logic [31:0]         r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_unused_bits;

    mem_arb_pick #(
        .MAX_WAIT     (MAX_WAIT)
    ) u_pick (
        .i_if_req     (bus.if_req),
        .i_dm_req     (bus.dm_req),
        .i_starve_cnt (r_starve_cnt),
        .o_winner     (w_winner),
        .o_gnt_vld    (w_gnt_vld)
    );

    // A completion cycle doubles as the next arbitration point (no bubble).
    assign w_arb_pt  = (r_state == IDLE) | bus.mem_ready;
    assign w_take    = w_arb_pt & w_gnt_vld;
    assign w_take_if = w_take & (w_winner == SRC_IF);
    assign w_take_dm = w_take & (w_winner == SRC_DM);
    assign w_done_if = (r_state == BUSY_IF) & bus.mem_ready;
    assign w_done_dm = (r_state == BUSY_DM) & bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_arb_pt) begin
            if (!w_gnt_vld) begin
                w_state_nxt = IDLE;
            end else if (w_winner == SRC_IF) begin
                w_state_nxt = BUSY_IF;
            end else begin
                w_state_nxt = BUSY_DM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_if_hi     <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_gnt   <= w_take_if;
            r_dm_gnt   <= w_take_dm;
            r_if_valid <= w_done_if;
            r_dm_valid <= w_done_dm;

            if (w_done_if) begin
                r_if_rdata <= sel_word(bus.mem_rdata[63:0], r_if_hi);
            end
            // r_mem_we still describes the access that is finishing here.
            if (w_done_dm && !r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
            end

            if (w_take_if) begin
                r_mem_addr <= {bus.if_addr[ADDR_W-1:3], 3'b000};
                r_mem_we   <= 1'b0;
                r_if_hi    <= bus.if_addr[2];
            end else if (w_take_dm) begin
                r_mem_addr  <= {bus.dm_addr[ADDR_W-1:3], 3'b000};
                r_mem_we    <= bus.dm_we;
                r_mem_wdata <= bus.dm_wdata;
            end else if (w_arb_pt) begin
                r_mem_we <= 1'b0;
            end
        end
    end

    // Run length of DM wins while IF sits waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.if_req || w_take_if) begin
            r_starve_cnt <= '0;
        end else if (w_take_dm && (r_starve_cnt != C_MAX_WAIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign bus.mem_req   = (r_state != IDLE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_gnt    = r_if_gnt;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.stall_if  = bus.if_req & ~r_if_valid;
    assign bus.stall_mem = bus.dm_req & ~r_dm_valid;

    // Sub-doubleword address bits never reach the memory.
    assign w_unused_bits = ^{bus.if_addr[1:0], bus.dm_addr[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter : scoreboard bench with a rule-level model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int stamp; bit mreq; logic [63:0] addr; bit we; logic [63:0] wdata; } cyc_t;
    typedef struct { int stamp; int src; } gnt_t;
    typedef struct { int stamp; logic [63:0] data; } val_t;

    cyc_t cq[$];
    gnt_t gq[$];
    val_t ivq[$];
    val_t dvq[$];

    // Reference model: owner 0 = none, 1 = IF, 2 = DM
    int          m_owner = 0;
    int          m_cnt = 0;
    bit          m_hi = 0;
    bit          m_we = 0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_dm_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: expected event absent at cycle %0d", name, cyc);
    endtask

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_dm_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 0;
        cq.delete(); gq.delete(); ivq.delete(); dvq.delete();
    endtask

    // Applies this cycle's inputs to the rules; results are due next cycle.
    task automatic model_step();
        bit ir, dr, arb;
        int win;
        ir = bus.if_req;
        dr = bus.dm_req;
        if (m_owner != 0 && bus.mem_ready) begin
            if (m_owner == 1) begin
                ivq.push_back('{cyc + 1, m_hi ? {32'h0, bus.mem_rdata[63:32]} : {32'h0, bus.mem_rdata[31:0]}});
            end else begin
                if (!m_we) m_dm_rdata = bus.mem_rdata;
                dvq.push_back('{cyc + 1, m_dm_rdata});
            end
        end
        arb = (m_owner == 0) || bus.mem_ready;
        win = 0;
        if (arb) begin
            if (ir && dr)  win = (m_cnt == MAX_WAIT) ? 1 : 2;
            else if (ir)   win = 1;
            else if (dr)   win = 2;
            m_owner = win;
            if (win == 1) begin
                m_addr = bus.if_addr & ~64'h7; m_we = 0; m_hi = bus.if_addr[2];
            end else if (win == 2) begin
                m_addr = bus.dm_addr & ~64'h7; m_we = bus.dm_we; m_wdata = bus.dm_wdata;
            end
            if (win != 0) gq.push_back('{cyc + 1, win});
        end
        if (win == 1 || !ir) m_cnt = 0;
        else if (win == 2 && m_cnt < MAX_WAIT) m_cnt++;
        cq.push_back('{cyc + 1, m_owner != 0, m_addr, m_we, m_wdata});
    endtask

    task automatic drive(input bit ir, input logic [63:0] ia, input bit dr, input bit dwe,
                         input logic [63:0] da, input logic [63:0] dwd,
                         input bit rdy, input logic [63:0] rd);
        @(posedge clk);
        #1;
        bus.if_req = ir; bus.if_addr = ia;
        bus.dm_req = dr; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
        bus.mem_ready = rdy; bus.mem_rdata = rd;
        #1;
        if (rst_n) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, '0, '0, 1, '0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    cyc_t mon_c;
    gnt_t mon_g;
    val_t mon_v;
    always @(negedge clk) begin
        if (rst_n) begin
            while (cq.size() > 0 && cq[0].stamp < cyc) begin miss("cycle_entry"); void'(cq.pop_front()); end
            while (gq.size() > 0 && gq[0].stamp < cyc) begin miss("grant"); void'(gq.pop_front()); end
            while (ivq.size() > 0 && ivq[0].stamp < cyc) begin miss("if_valid"); void'(ivq.pop_front()); end
            while (dvq.size() > 0 && dvq[0].stamp < cyc) begin miss("dm_valid"); void'(dvq.pop_front()); end

            if (cq.size() > 0 && cq[0].stamp == cyc) begin
                mon_c = cq.pop_front();
                chk("mem_req", bus.mem_req, mon_c.mreq);
                if (mon_c.mreq) begin
                    chk("mem_addr", bus.mem_addr, mon_c.addr);
                    chk("mem_we", bus.mem_we, mon_c.we);
                    if (mon_c.we) chk("mem_wdata", bus.mem_wdata, mon_c.wdata);
                end
            end
            if (bus.if_gnt || bus.dm_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {bus.dm_gnt, bus.if_gnt}, 2'b00);
                end else begin
                    mon_g = gq.pop_front();
                    chk("gnt_cycle", cyc, mon_g.stamp);
                    chk("gnt_src", {bus.dm_gnt, bus.if_gnt}, (mon_g.src == 1) ? 2'b01 : 2'b10);
                end
            end
            if (bus.if_valid) begin
                if (ivq.size() == 0) chk("unexpected_if_valid", bus.if_valid, 1'b0);
                else begin
                    mon_v = ivq.pop_front();
                    chk("if_valid_cycle", cyc, mon_v.stamp);
                    chk("if_rdata", bus.if_rdata, mon_v.data);
                end
            end
            if (bus.dm_valid) begin
                if (dvq.size() == 0) chk("unexpected_dm_valid", bus.dm_valid, 1'b0);
                else begin
                    mon_v = dvq.pop_front();
                    chk("dm_valid_cycle", cyc, mon_v.stamp);
                    chk("dm_rdata", bus.dm_rdata, mon_v.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ir, dr, dwe;
        logic [63:0] ia, da, dwd;
        ir = 0; dr = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_gnts", {bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid, bus.mem_we}, 5'b0);
        chk("rst_mem_addr", bus.mem_addr, 64'h0);
        chk("rst_rdata", {bus.if_rdata, bus.dm_rdata[31:0]}, 64'h0);
        @(posedge clk); #1 rst_n = 1; #1 model_step();
        idle(2);

        // IF read of 0x4, memory ready on the first busy cycle
        drive(1, 64'h4, 0, 0, '0, '0, 0, '0);
        @(negedge clk); chk("t1_stall_if", bus.stall_if, 1'b1);
        drive(0, 64'h4, 0, 0, '0, '0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
        @(negedge clk); chk("t1_if_gnt", bus.if_gnt, 1'b1); chk("t1_mem_addr", bus.mem_addr, 64'h0);
        drive(0, 64'h4, 0, 0, '0, '0, 0, '0);
        @(negedge clk); chk("t1_if_valid", bus.if_valid, 1'b1); chk("t1_if_rdata", bus.if_rdata, 32'hAAAA_BBBB);
        idle(2);

        // DM store to 0x10 held three cycles before the memory responds
        drive(0, '0, 1, 1, 64'h10, 64'h1234, 0, '0);
        @(negedge clk); chk("t2_stall_mem_req", bus.stall_mem, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 1, 64'h10, 64'h1234, 0, '0);
            @(negedge clk);
            chk("t2_hold_addr", bus.mem_addr, 64'h10);
            chk("t2_hold_we", bus.mem_we, 1'b1);
            chk("t2_hold_wdata", bus.mem_wdata, 64'h1234);
            chk("t2_stall_mem", bus.stall_mem, 1'b1);
        end
        drive(0, '0, 1, 1, 64'h10, 64'h1234, 1, '0);
        @(negedge clk); chk("t2_stall_ready_cycle", bus.stall_mem, 1'b1);
        drive(0, '0, 0, 1, 64'h10, 64'h1234, 0, '0);
        @(negedge clk); chk("t2_dm_valid", bus.dm_valid, 1'b1); chk("t2_stall_released", bus.stall_mem, 1'b0);
        idle(3);

        // Both requesters held, memory always ready: DM x4 then IF
        for (int k = 0; k <= 10; k++) begin
            drive(1, 64'h100, 1, 0, 64'h200, '0, 1, 64'h5555);
            @(negedge clk);
            if (k >= 1) chk("t3_arb_seq", {bus.dm_gnt, bus.if_gnt}, ((k - 1) % 5 == 4) ? 2'b01 : 2'b10);
        end
        idle(3);

        // DM load completes while IF waits: dm_valid and if_gnt coincide
        drive(0, '0, 1, 0, 64'h20, '0, 0, '0);
        drive(1, 64'h8, 0, 0, 64'h20, '0, 0, '0);
        drive(1, 64'h8, 0, 0, 64'h20, '0, 1, 64'h0123_4567_89AB_CDEF);
        drive(0, 64'h8, 0, 0, 64'h20, '0, 1, 64'h1111_2222_3333_4444);
        @(negedge clk);
        chk("t4_dm_valid", bus.dm_valid, 1'b1);
        chk("t4_if_gnt", bus.if_gnt, 1'b1);
        chk("t4_dm_rdata", bus.dm_rdata, 64'h0123_4567_89AB_CDEF);
        idle(3);

        // Reset in the second busy cycle of a DM load
        drive(1, 64'h40, 1, 0, 64'h30, '0, 0, '0);
        drive(1, 64'h40, 1, 0, 64'h30, '0, 0, '0);
        drive(1, 64'h40, 1, 0, 64'h30, '0, 0, '0);
        #1 rst_n = 0;
        model_reset();
        #1 chk("t5_mem_req_drop", bus.mem_req, 1'b0);
        bus.if_req = 0; bus.dm_req = 0;
        @(negedge clk);
        chk("t5_no_valid", {bus.dm_valid, bus.if_valid, bus.dm_gnt}, 3'b000);
        chk("t5_dm_rdata_clr", bus.dm_rdata, 64'h0);
        @(posedge clk); #1 rst_n = 1; #1 model_step();
        @(negedge clk); chk("t5_idle_after", bus.mem_req, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            drive(1, 64'h40, 1, 0, 64'h30, '0, 1, 64'h77);
            @(negedge clk);
            if (k >= 1) chk("t5_cnt_cleared", {bus.dm_gnt, bus.if_gnt}, (k == 5) ? 2'b01 : 2'b10);
        end
        idle(3);

        // IF req dropped while its access is in flight
        drive(1, 64'h104, 0, 0, '0, '0, 0, '0);
        drive(0, 64'h104, 0, 0, '0, '0, 0, '0);
        drive(0, 64'h104, 0, 0, '0, '0, 1, 64'hDEAD_BEEF_0BAD_F00D);
        drive(0, 64'h104, 0, 0, '0, '0, 0, '0);
        @(negedge clk);
        chk("t6_if_valid", bus.if_valid, 1'b1);
        chk("t6_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("t6_idle", bus.mem_req, 1'b0);
        drive(0, '0, 0, 0, '0, '0, 0, '0);
        @(negedge clk); chk("t6_single_valid", bus.if_valid, 1'b0);
        idle(2);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            if (!ir) begin
                if ($urandom_range(0, 9) < 4) begin ir = 1; ia = {$urandom(), $urandom()}; end
            end else if ($urandom_range(0, 9) < 2) ir = 0;
            if (!dr) begin
                if ($urandom_range(0, 9) < 4) begin
                    dr = 1; da = {$urandom(), $urandom()}; dwd = {$urandom(), $urandom()};
                    dwe = $urandom_range(0, 1) == 1;
                end
            end else if ($urandom_range(0, 9) < 2) dr = 0;
            drive(ir, ia, dr, dwe, da, dwd, $urandom_range(0, 9) < 6, {$urandom(), $urandom()});
        end
        idle(8);
        @(negedge clk);
        chk("leftover_gnt", gq.size(), 0);
        chk("leftover_if_valid", ivq.size(), 0);
        chk("leftover_dm_valid", dvq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
